armleo_cpu_tlb: RTL and testbench
=================================

// Module: armleo_cpu_tlb
// PURPOSE
//  Sv32 translation lookaside buffer for the ArmleoCPU MMU. Caches VPN->PPN
//  translations plus PTE flag bytes, and resolves a 20-bit virtual page number
//  with a one-cycle registered result. Direct-mapped; written by the page-table
//  walker and flushed by SFENCE.VMA through the invalidate input.
// PARAMETERS
//  ENTRIES_W  3  log2 of entry count (8 entries); index = virtual_address[ENTRIES_W-1:0]
// PORTS
//  clk                input   1   clock; all state updates on rising edge
//  rst_n              input   1   synchronous active-low reset
//  enable             input   1   1 = translation on, 0 = bare (identity) mode
//  resolve            input   1   lookup request, sampled each rising edge
//  virtual_address    input   20  VPN to look up
//  miss               output  1   registered; lookup missed (valid only when done=1)
//  done               output  1   registered; result available this cycle
//  phys_r             output  22  registered PPN result
//  accesstag_r        output  8   registered PTE flags {D,A,G,U,X,W,R,V}
//  write              input   1   write one entry this cycle
//  virtual_address_w  input   20  VPN of entry to write
//  phys_w             input   22  PPN to store
//  accesstag_w        input   8   flags to store; bit0 (V) marks entry valid
//  invalidate         input   1   clear every valid bit
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all valid bits 0; done=0, miss=0, phys_r=0, accesstag_r=0.
//  - Storage per entry: valid, tag = VPN[19:ENTRIES_W], phys[21:0], accesstag[7:0].
//  - Lookup latency 1: edge with resolve=1 -> next cycle done=1; done=0 otherwise.
//    Holding resolve high yields done=1 every cycle, each with a fresh result.
//  - enable=0: done=1, miss=0, phys_r={2'b00,virtual_address}, accesstag_r=8'hFF.
//  - enable=1: hit = valid[idx] && tag[idx]==VPN[19:ENTRIES_W];
//    hit -> miss=0, phys_r/accesstag_r from entry; else miss=1, phys_r/accesstag_r=0.
//  - When done=0, miss=0 and phys_r/accesstag_r hold their last value.
//  - Write: entry[virtual_address_w idx] <= {accesstag_w[0], tag, phys_w, accesstag_w}
//    at the edge; overwrites unconditionally (direct-mapped replacement).
//    accesstag_w[0]=0 therefore invalidates that entry.
//  - Lookup and write of the same entry in the same cycle: lookup returns the old contents.
//  - invalidate: clears all valid bits at the edge. It beats a simultaneous write,
//    which is dropped. A same-cycle lookup returns pre-invalidate contents.
//  - Inputs are only sampled at edges; no combinational path from input to output.
// CONFIGURATION
//  ARMLEOCPU_TLB_ASSERT_EN defined: simulation-only checks. Each $error fires on:
//    X/Z on resolve, write or invalidate while out of reset;
//    write and invalidate asserted together;
//    done=1 with miss=1 while enable was 0.
//  Undefined: no checks are compiled, and the RTL is identical otherwise.
// STRUCTURE
//  - Package armleocpu_tlb_pkg holds the following:
//    VPN_W=20, PPN_W=22, TAG_FLAGS_W=8;
//    flag bit indices (V=0, R, W, X, U, G, A, D=7);
//    typedef tlb_entry_t {valid, tag, phys, accesstag}.
//  - One sub-module, armleocpu_tlb_ram: an array of tlb_entry_t with one write port,
//    one registered read port, and a flash-clear of the valid bits.
//  - Top level handles hit compare, bypass mux and done/miss registers.
// TESTING
//  1 enable=0, resolve=1, VA=0 -> done=0 at first edge, done=1 miss=0 at next.
//  2 after reset, enable=1, resolve VA=0 for 1 cycle -> done=1, miss=1 next cycle.
//  3 write VPN 0x20000/0x20001/0x20002 with PPN 0x10000/1/2 and flags 0xB1/0xB3/0xB5;
//    resolve each -> miss=0 with matching phys_r and accesstag_r.
//  4 invalidate 1 cycle, then resolve VA=0x20002 -> done=1, miss=1.
//  5 write VPN 0x20000, then resolve VA 0x28000 (same index, other tag) -> miss=1;
//    then write VPN 0x20008 with accesstag_w=0xB0 and resolve it -> miss=1.
//  6 rst_n=0 mid-resolve -> done=0 next cycle; a resolve after reset -> miss=1.

Source files
------------

// File: rtl/armleocpu_tlb_pkg.sv
// Shared widths, PTE flag bit positions and the TLB entry layout.
package armleocpu_tlb_pkg;

  localparam int VPN_W       = 20;
  localparam int PPN_W       = 22;
  localparam int TAG_FLAGS_W = 8;

  // PTE flag bit indices inside accesstag {D,A,G,U,X,W,R,V}
  localparam int FLAG_V = 0;
  localparam int FLAG_R = 1;
  localparam int FLAG_W = 2;
  localparam int FLAG_X = 3;
  localparam int FLAG_U = 4;
  localparam int FLAG_G = 5;
  localparam int FLAG_A = 6;
  localparam int FLAG_D = 7;

  // Tag is held VPN-wide (VPN >> ENTRIES_W, upper bits zero) so the layout
  // does not depend on the entry-count parameter of the instantiating module.
  typedef struct packed {
    logic                   valid;
    logic [VPN_W-1:0]       tag;
    logic [PPN_W-1:0]       phys;
    logic [TAG_FLAGS_W-1:0] accesstag;
  } tlb_entry_t;

endpackage

// File: rtl/armleocpu_tlb_ram.sv
// Direct-mapped TLB entry storage: one write port, one registered read port,
// flash-clear of all valid bits (clear beats a same-cycle write).
module armleocpu_tlb_ram
  import armleocpu_tlb_pkg::*;
#(
  parameter int ENTRIES_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_en,
  input  logic [ENTRIES_W-1:0] rd_idx,
  output tlb_entry_t           rd_entry,
  input  logic                 wr_en,
  input  logic [ENTRIES_W-1:0] wr_idx,
  input  tlb_entry_t           wr_entry,
  input  logic                 clear
);

  localparam int unsigned ENTRIES = 1 << ENTRIES_W;

  tlb_entry_t mem_q [ENTRIES];
  tlb_entry_t mem_d [ENTRIES];
  tlb_entry_t rd_q;
  tlb_entry_t rd_d;

  // Next storage contents and read register; read sees pre-edge contents
  always_comb begin
    mem_d = mem_q;
    if (clear) begin
      for (int unsigned i = 0; i < ENTRIES; i++) mem_d[i].valid = 1'b0;
    end else if (wr_en) begin
      mem_d[wr_idx] = wr_entry;
    end
    rd_d = rd_en ? mem_q[rd_idx] : rd_q;
  end

  // Storage and read-port registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_entry = rd_q;

endmodule

// File: rtl/armleo_cpu_tlb.sv
// Sv32 TLB for the ArmleoCPU MMU: direct-mapped, one-cycle registered lookup,
// bare-mode bypass when enable=0.
// Optional simulation checks: define ARMLEOCPU_TLB_ASSERT_EN.
module armleo_cpu_tlb
  import armleocpu_tlb_pkg::*;
#(
  parameter int ENTRIES_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   resolve,
  input  logic [VPN_W-1:0]       virtual_address,
  output logic                   miss,
  output logic                   done,
  output logic [PPN_W-1:0]       phys_r,
  output logic [TAG_FLAGS_W-1:0] accesstag_r,
  input  logic                   write,
  input  logic [VPN_W-1:0]       virtual_address_w,
  input  logic [PPN_W-1:0]       phys_w,
  input  logic [TAG_FLAGS_W-1:0] accesstag_w,
  input  logic                   invalidate
);

  tlb_entry_t       rd_entry;
  tlb_entry_t       wr_entry;
  logic             done_q, done_d;
  logic             enable_q, enable_d;
  logic [VPN_W-1:0] va_q, va_d;
  logic             hit;
  logic             miss_raw;

  assign wr_entry = '{valid:     accesstag_w[FLAG_V],
                      tag:       virtual_address_w >> ENTRIES_W,
                      phys:      phys_w,
                      accesstag: accesstag_w};

  armleocpu_tlb_ram #(.ENTRIES_W(ENTRIES_W)) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (resolve),
    .rd_idx   (virtual_address[ENTRIES_W-1:0]),
    .rd_entry (rd_entry),
    .wr_en    (write),
    .wr_idx   (virtual_address_w[ENTRIES_W-1:0]),
    .wr_entry (wr_entry),
    .clear    (invalidate)
  );

  // Capture request context alongside the RAM read; held while idle
  always_comb begin
    done_d   = resolve;
    enable_d = resolve ? enable : enable_q;
    va_d     = resolve ? virtual_address : va_q;
  end

  // Request registers; enable_q resets to 1 so the idle result after
  // reset decodes as an all-zero miss rather than a bypass
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      enable_q <= 1'b1;
      va_q     <= '0;
    end else begin
      done_q   <= done_d;
      enable_q <= enable_d;
      va_q     <= va_d;
    end
  end

  // Result decode from registered state only; since every source holds
  // while idle, the outputs hold their last value when done=0
  always_comb begin
    hit         = rd_entry.valid && (rd_entry.tag == (va_q >> ENTRIES_W));
    miss_raw    = 1'b0;
    phys_r      = '0;
    accesstag_r = '0;
    if (!enable_q) begin
      phys_r      = {2'b00, va_q};
      accesstag_r = '1;
    end else if (hit) begin
      phys_r      = rd_entry.phys;
      accesstag_r = rd_entry.accesstag;
    end else begin
      miss_raw    = 1'b1;
    end
  end

  assign done = done_q;
  assign miss = done_q & miss_raw;

`ifdef ARMLEOCPU_TLB_ASSERT_EN
  // Simulation-only protocol checks
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if ($isunknown({resolve, write, invalidate}))
        $error("armleo_cpu_tlb: X/Z on resolve/write/invalidate");
      if (write && invalidate)
        $error("armleo_cpu_tlb: write and invalidate asserted together");
      if (done && miss && !enable_q)
        $error("armleo_cpu_tlb: miss reported in bare mode");
    end
  end
`endif

endmodule

// File: tb/tb_armleo_cpu_tlb.sv
// Directed self-checking bench for armleo_cpu_tlb.
module tb_armleo_cpu_tlb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        resolve;
  logic [19:0] virtual_address;
  logic        miss;
  logic        done;
  logic [21:0] phys_r;
  logic [7:0]  accesstag_r;
  logic        write;
  logic [19:0] virtual_address_w;
  logic [21:0] phys_w;
  logic [7:0]  accesstag_w;
  logic        invalidate;

  int n_checks = 0;
  int n_fail   = 0;

  armleo_cpu_tlb #(.ENTRIES_W(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .resolve           (resolve),
    .virtual_address   (virtual_address),
    .miss              (miss),
    .done              (done),
    .phys_r            (phys_r),
    .accesstag_r       (accesstag_r),
    .write             (write),
    .virtual_address_w (virtual_address_w),
    .phys_w            (phys_w),
    .accesstag_w       (accesstag_w),
    .invalidate        (invalidate)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_res(input string name, input logic d, input logic m,
                         input logic [21:0] p, input logic [7:0] a);
    chk({name, ".done"}, {31'd0, done}, {31'd0, d});
    chk({name, ".miss"}, {31'd0, miss}, {31'd0, m});
    chk({name, ".phys"}, {10'd0, phys_r}, {10'd0, p});
    chk({name, ".tag"},  {24'd0, accesstag_r}, {24'd0, a});
  endtask

  task automatic do_write(input logic [19:0] va, input logic [21:0] p, input logic [7:0] a);
    write = 1'b1; virtual_address_w = va; phys_w = p; accesstag_w = a;
    tick();
    write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; resolve = 1'b0; virtual_address = '0;
    write = 1'b0; virtual_address_w = '0; phys_w = '0; accesstag_w = '0;
    invalidate = 1'b0;
    tick(); tick();
    chk_res("reset", 1'b0, 1'b0, 22'h0, 8'h00);

    // 1: bare mode, one-cycle latency
    rst_n = 1'b1; enable = 1'b0; resolve = 1'b1; virtual_address = 20'h00000;
    chk_res("bare_pre", 1'b0, 1'b0, 22'h0, 8'h00);
    tick();
    chk_res("bare_va0", 1'b1, 1'b0, 22'h0, 8'hFF);
    virtual_address = 20'h12345;
    tick();
    chk_res("bare_va12345", 1'b1, 1'b0, 22'h012345, 8'hFF);

    // 2: empty TLB misses
    enable = 1'b1; virtual_address = 20'h00000;
    tick();
    resolve = 1'b0;
    chk_res("empty_miss", 1'b1, 1'b1, 22'h0, 8'h00);
    tick();
    chk_res("idle_after_miss", 1'b0, 1'b0, 22'h0, 8'h00);

    // 3: fill three entries and hit each while holding resolve
    do_write(20'h20000, 22'h010000, 8'hB1);
    do_write(20'h20001, 22'h010001, 8'hB3);
    do_write(20'h20002, 22'h010002, 8'hB5);
    resolve = 1'b1; virtual_address = 20'h20000;
    tick();
    chk_res("hit_20000", 1'b1, 1'b0, 22'h010000, 8'hB1);
    virtual_address = 20'h20001;
    tick();
    chk_res("hit_20001", 1'b1, 1'b0, 22'h010001, 8'hB3);
    virtual_address = 20'h20002;
    tick();
    resolve = 1'b0;
    chk_res("hit_20002", 1'b1, 1'b0, 22'h010002, 8'hB5);
    tick();
    chk_res("hold_idle", 1'b0, 1'b0, 22'h010002, 8'hB5);

    // same-cycle lookup and write of one entry returns old contents
    resolve = 1'b1; virtual_address = 20'h20001;
    do_write(20'h20001, 22'h03AAAA, 8'hC7);
    chk_res("rd_wr_old", 1'b1, 1'b0, 22'h010001, 8'hB3);
    tick();
    resolve = 1'b0;
    chk_res("rd_wr_new", 1'b1, 1'b0, 22'h03AAAA, 8'hC7);

    // 4: invalidate beats write; same-cycle lookup sees old contents
    resolve = 1'b1; virtual_address = 20'h20002;
    invalidate = 1'b1;
    write = 1'b1; virtual_address_w = 20'h20003; phys_w = 22'h000333; accesstag_w = 8'hB1;
    tick();
    invalidate = 1'b0; write = 1'b0;
    chk_res("inv_same_cycle", 1'b1, 1'b0, 22'h010002, 8'hB5);
    tick();
    chk_res("inv_miss_20002", 1'b1, 1'b1, 22'h0, 8'h00);
    virtual_address = 20'h20003;
    tick();
    resolve = 1'b0;
    chk_res("inv_dropped_wr", 1'b1, 1'b1, 22'h0, 8'h00);

    // 5: tag conflict and V=0 write
    do_write(20'h20000, 22'h000123, 8'hB1);
    resolve = 1'b1; virtual_address = 20'h28000;
    tick();
    chk_res("tag_conflict", 1'b1, 1'b1, 22'h0, 8'h00);
    virtual_address = 20'h20000;
    tick();
    resolve = 1'b0;
    chk_res("tag_match", 1'b1, 1'b0, 22'h000123, 8'hB1);
    do_write(20'h20008, 22'h000456, 8'hB0);
    resolve = 1'b1; virtual_address = 20'h20008;
    tick();
    chk_res("v0_write_miss", 1'b1, 1'b1, 22'h0, 8'h00);
    virtual_address = 20'h20000;
    tick();
    resolve = 1'b0;
    chk_res("v0_replaced", 1'b1, 1'b1, 22'h0, 8'h00);

    // top index and all-ones values
    do_write(20'hFFFFF, 22'h3FFFFF, 8'hFF);
    resolve = 1'b1; virtual_address = 20'hFFFFF;
    tick();
    chk_res("hit_top", 1'b1, 1'b0, 22'h3FFFFF, 8'hFF);

    // 6: reset mid-resolve
    rst_n = 1'b0;
    tick();
    chk_res("rst_mid", 1'b0, 1'b0, 22'h0, 8'h00);
    rst_n = 1'b1;
    tick();
    resolve = 1'b0;
    chk_res("rst_cleared", 1'b1, 1'b1, 22'h0, 8'h00);
    tick();
    chk_res("final_idle", 1'b0, 1'b0, 22'h0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
